// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter: FSM encoding and timing constants.
package freq_meter_pkg;

  // Measurement FSM encoding.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StMeasure = 2'd1,
    StPublish = 2'd2
  } fm_state_e;

  // System clock frequency in Hz.
  localparam int unsigned CLK_HZ = 100000000;

  // Default gate: one second of system clock.
  localparam int unsigned GATE_CYCLES_DEFAULT = CLK_HZ;

  // Gate timer width; wide enough for any legal gate length.
  localparam int unsigned TIMER_W = 32;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizes an asynchronous input into the clk domain and emits a
// registered one-cycle pulse for every rising edge of the synchronized value.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   rise_q, rise_d;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // Next state: shift the synchronizer, remember last synced value, detect 0->1.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
    prev_d = synced;
    rise_d = synced & ~prev_q;
  end

  // State registers; everything clears to 0 so a high input after reset reads as a rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/freq_meter.sv
// Gated frequency meter: counts rising edges of an asynchronous input over a
// fixed window of GATE_CYCLES clocks and publishes the count with a strobe.
// Legal GATE_CYCLES range is 2 .. 2^32-1; SYNC_STAGES must be at least 2.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = GATE_CYCLES_DEFAULT,
  parameter int unsigned COUNT_W     = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               sig_in,
  output logic [COUNT_W-1:0] freq_count,
  output logic               freq_valid,
  output logic               overflow,
  output logic               busy
);

  localparam logic [TIMER_W-1:0] GateLast = TIMER_W'(GATE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] CountMax = '1;

  fm_state_e state_q, state_d;

  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               sat_q, sat_d;
  logic [COUNT_W-1:0] freq_count_q, freq_count_d;
  logic               overflow_q, overflow_d;
  logic               valid_q, valid_d;

  logic rise;
  logic in_measure;
  logic in_publish;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge_detect (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(sig_in),
    .rise_o (rise)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; dropping en abandons a window even on its last cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (en) state_d = StMeasure;
      end
      StMeasure: begin
        if (!en) begin
          state_d = StIdle;
        end else if (timer_q == GateLast) begin
          state_d = StPublish;
        end
      end
      StPublish: begin
        state_d = en ? StMeasure : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs; the publish cycle still counts as part of an active measurement.
  always_comb begin
    in_measure = (state_q == StMeasure);
    in_publish = (state_q == StPublish);
    busy       = in_measure | in_publish;
  end

  // Datapath next state: gate timer, saturating edge counter, published results.
  always_comb begin
    timer_d      = '0;
    cnt_d        = '0;
    sat_d        = 1'b0;
    freq_count_d = freq_count_q;
    overflow_d   = overflow_q;
    valid_d      = 1'b0;

    if (in_measure && en) begin
      timer_d = timer_q + TIMER_W'(1);
      cnt_d   = cnt_q;
      sat_d   = sat_q;
      if (rise) begin
        if (cnt_q == CountMax) begin
          sat_d = 1'b1;
        end else begin
          cnt_d = cnt_q + COUNT_W'(1);
        end
      end
    end

    if (in_publish) begin
      freq_count_d = cnt_q;
      overflow_d   = sat_q;
      valid_d      = 1'b1;
      // An edge seen during the publish cycle opens the next window.
      if (en && rise) cnt_d = COUNT_W'(1);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q      <= '0;
      cnt_q        <= '0;
      sat_q        <= 1'b0;
      freq_count_q <= '0;
      overflow_q   <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      timer_q      <= timer_d;
      cnt_q        <= cnt_d;
      sat_q        <= sat_d;
      freq_count_q <= freq_count_d;
      overflow_q   <= overflow_d;
      valid_q      <= valid_d;
    end
  end

  assign freq_count = freq_count_q;
  assign overflow   = overflow_q;
  assign freq_valid = valid_q;

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter against a cycle-level window model.
module tb_freq_meter;

  localparam int unsigned G    = 1000;
  localparam int unsigned CW   = 8;
  localparam int unsigned SS   = 2;
  localparam int          CMAX = (1 << CW) - 1;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          en     = 1'b0;
  logic          sig_in = 1'b0;
  logic [CW-1:0] freq_count;
  logic          freq_valid;
  logic          overflow;
  logic          busy;

  freq_meter #(
    .GATE_CYCLES(G),
    .COUNT_W    (CW),
    .SYNC_STAGES(SS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .sig_in    (sig_in),
    .freq_count(freq_count),
    .freq_valid(freq_valid),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: samples of sig_in (most recent first), window progress,
  // and an unbounded edge tally that is clamped only when published.
  logic h1, h2, h3, h4;
  bit   m_active, m_pub;
  int   m_t, m_edges;
  int   exp_count;
  logic exp_valid, exp_ovf;

  task automatic model_reset();
    h1 = 0; h2 = 0; h3 = 0; h4 = 0;
    m_active = 0; m_pub = 0; m_t = 0; m_edges = 0;
    exp_count = 0; exp_valid = 0; exp_ovf = 0;
  endtask

  task automatic model_step(input logic en_v, input logic s_v);
    logic r;
    // A rise sampled at edge n is counted at edge n+SS+1.
    r  = h3 & ~h4;
    h4 = h3; h3 = h2; h2 = h1; h1 = s_v;
    exp_valid = 0;
    if (m_pub) begin
      exp_valid = 1;
      exp_count = (m_edges > CMAX) ? CMAX : m_edges;
      exp_ovf   = (m_edges > CMAX);
      m_pub     = 0;
      m_active  = en_v;
      m_t       = 0;
      m_edges   = (en_v && r) ? 1 : 0;
    end else if (m_active) begin
      if (!en_v) begin
        m_active = 0; m_t = 0; m_edges = 0;
      end else begin
        m_edges += int'(r);
        m_t++;
        if (m_t == int'(G)) begin
          m_active = 0;
          m_pub    = 1;
        end
      end
    end else if (en_v) begin
      m_active = 1; m_t = 0; m_edges = 0;
    end
  endtask

  int   n_valid = 0;
  int   v_count = 0;
  logic v_ovf   = 0;

  task automatic check_outputs();
    check_eq("freq_valid", freq_valid, exp_valid);
    check_eq("freq_count", freq_count, exp_count);
    check_eq("overflow", overflow, exp_ovf);
    check_eq("busy", busy, m_active || m_pub);
  endtask

  // One clock: drive inputs (optionally with a sub-cycle glitch), step model, compare.
  task automatic tick(input logic en_v, input logic s_v, input logic glitch);
    en = en_v;
    sig_in = s_v;
    if (glitch) begin
      #2 sig_in = ~s_v;
      #2 sig_in = s_v;
    end
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(en_v, s_v);
    #1;
    check_outputs();
    if (freq_valid) begin
      n_valid++;
      v_count = int'(freq_count);
      v_ovf   = overflow;
    end
  endtask

  logic sq = 0;
  int   ph = 0;

  // Square wave with half period 'half' clocks; half==0 holds sq.
  task automatic run_sq(input int n, input logic en_v, input int half);
    for (int i = 0; i < n; i++) begin
      if (half > 0) begin
        ph++;
        if (ph >= half) begin
          ph = 0;
          sq = ~sq;
        end
      end
      tick(en_v, sq, 1'b0);
    end
  endtask

  task automatic wait_valid(input int max, input logic en_v, input int half, output int took);
    took = 0;
    for (int i = 0; i < max; i++) begin
      run_sq(1, en_v, half);
      if (freq_valid) begin
        took = i + 1;
        break;
      end
    end
    check_eq("valid_seen", took != 0, 1);
  endtask

  // Assert reset between clock edges, check outputs clear at once, then release.
  task automatic async_reset(input int dly, input int hold, input logic en_v, input int half);
    #(dly) rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    run_sq(hold, en_v, half);
    rst_n = 1'b1;
  endtask

  int took;
  int nv_before;
  int held;
  bit found;

  initial begin
    model_reset();
    // Reset held through a few clocks.
    run_sq(3, 1'b0, 0);
    check_eq("rst_count", freq_count, 0);
    rst_n = 1'b1;

    // Period-100 input: first result after the full window, then every 1001.
    sq = 0; ph = 0;
    wait_valid(1100, 1'b1, 50, took);
    check_eq("first_latency", took, G + 2);
    check_eq("win1_count", v_count, 10);
    check_eq("win1_ovf", v_ovf, 0);
    wait_valid(1100, 1'b1, 50, took);
    check_eq("win2_period", took, G + 1);
    wait_valid(1100, 1'b1, 50, took);
    check_eq("win3_period", took, G + 1);

    // Constant high input: no edges once settled.
    sq = 1;
    wait_valid(1100, 1'b1, 0, took);
    wait_valid(1100, 1'b1, 0, took);
    check_eq("const_count", v_count, 0);

    // Single rise detected in the last measure cycle of a window.
    sq = 0;
    wait_valid(1100, 1'b1, 0, took);
    found = 0;
    for (int i = 0; i < 2100 && !found; i++) begin
      if (m_active && m_t == int'(G) - 4) begin
        sq = 1;
        found = 1;
      end
      tick(1'b1, sq, 1'b0);
    end
    check_eq("last_cycle_aligned", found, 1);
    wait_valid(1100, 1'b1, 0, took);
    check_eq("last_cycle_count", v_count, 1);
    wait_valid(1100, 1'b1, 0, took);
    check_eq("after_last_count", v_count, 0);

    // Toggle every clock: saturates; then a period-100 window clears overflow.
    wait_valid(1100, 1'b1, 1, took);
    check_eq("sat_count", v_count, CMAX);
    check_eq("sat_ovf", v_ovf, 1);
    wait_valid(1100, 1'b1, 50, took);
    check_eq("post_sat_ovf", v_ovf, 0);
    wait_valid(1100, 1'b1, 50, took);
    check_eq("post_sat_count", v_count, 10);

    // Drop en mid-window: nothing published, result held; re-enable starts fresh.
    held = v_count;
    run_sq(600, 1'b1, 50);
    nv_before = n_valid;
    run_sq(1200, 1'b0, 50);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_no_valid", n_valid, nv_before);
    check_eq("idle_hold_count", freq_count, held);
    wait_valid(1100, 1'b1, 50, took);
    check_eq("reen_latency", took, G + 2);
    check_eq("reen_count", v_count, 10);

    // Asynchronous reset mid-window, released with en high and input low.
    run_sq(400, 1'b1, 50);
    async_reset(3, 3, 1'b1, 50);
    sq = 0; ph = 0;
    wait_valid(1100, 1'b1, 50, took);
    check_eq("rst_latency", took, G + 2);
    check_eq("rst_count", v_count, 10);

    // Sub-cycle glitches (never sampled) mixed with one-clock pulses.
    sq = 0;
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 29));
      if (r == 0) begin
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
      end else begin
        tick(1'b1, 1'b0, r < 6);
      end
    end

    // Random segments: random periods, enable gaps and occasional resets.
    for (int s = 0; s < 20; s++) begin
      int   half;
      int   len;
      logic en_v;
      half = int'($urandom_range(1, 80));
      len  = int'($urandom_range(50, 600));
      en_v = ($urandom_range(0, 7) != 0);
      run_sq(len, en_v, half);
      if ($urandom_range(0, 9) == 0) async_reset(int'($urandom_range(1, 7)), 2, en_v, half);
    end
    run_sq(2100, 1'b1, 37);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
